dmem_access_ctrl: RTL and testbench

DMEM_ACCESS_CTRL -- requirements
Module: dmem_access_ctrl

---
 rtl/dmem_access_ctrl_pkg.sv | 36 +++
 rtl/dmem_access_ctrl_load_extend.sv | 31 +++
 rtl/dmem_access_ctrl.sv | 139 +++++++++++++
 tb/tb_dmem_access_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_access_ctrl_pkg.sv
// Shared encodings for the data-memory access controller: funct3 access codes,
// FSM state encoding and small decode helpers used by the top and load_extend.
package dmem_access_ctrl_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_RSP = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  // Legal encoding and natural alignment for the requested access size.
  function automatic logic access_aligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      F3_B, F3_BU: return 1'b1;
      F3_H, F3_HU: return ~lo[0];
      F3_W:        return lo == 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b00:   return 4'b0001 << lo;
      2'b01:   return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_load_extend.sv
// Picks the addressed byte/halfword out of a read word and sign- or zero-extends
// it according to the load's funct3. Purely combinational.
module dmem_access_ctrl_load_extend
  import dmem_access_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic [2:0]            i_funct3,
  input  logic [1:0]            i_addr_lo,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    o_data = i_rdata;
    case (i_funct3)
      F3_B:    o_data = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
      F3_BU:   o_data = {{(DATA_WIDTH-8){1'b0}}, w_byte};
      F3_H:    o_data = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
      F3_HU:   o_data = {{(DATA_WIDTH-16){1'b0}}, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data memory access controller: turns a load/store from EX/MEM into a
// valid/ready bus request, stalls the pipeline until it completes, flags bad accesses.
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_ADDR_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       mem_read_EX_MEM_o,
  input  logic                       mem_write_EX_MEM_o,
  input  logic [DATA_ADDR_WIDTH-1:0] alu_res_EX_MEM_o,
  input  logic [DATA_WIDTH-1:0]      write_data_EX_MEM_o,
  input  logic [2:0]                 funct3_EX_MEM_o,
  output logic                       dmem_req_valid,
  output logic                       dmem_we,
  input  logic                       dmem_req_ready,
  output logic [DATA_ADDR_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0]      dmem_wdata,
  output logic [3:0]                 dmem_wstrb,
  input  logic                       dmem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]      dmem_rdata,
  output logic [DATA_WIDTH-1:0]      read_data_MEM,
  output logic                       mem_stall_MEM,
  output logic                       misaligned_MEM
);

  state_t                       r_state;
  logic                         r_req_valid;
  logic                         r_we;
  logic [DATA_ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]        r_wdata;
  logic [3:0]                   r_wstrb;
  logic [2:0]                   r_funct3;
  logic [1:0]                   r_addr_lo;
  logic [DATA_WIDTH-1:0]        r_read_data;

  logic                         w_any;
  logic                         w_legal;
  logic                         w_idle;
  logic                         w_start;
  logic                         w_stall;
  logic [DATA_WIDTH-1:0]        w_st_wdata;
  logic [DATA_WIDTH-1:0]        w_load_data;

  assign w_any   = mem_read_EX_MEM_o | mem_write_EX_MEM_o;
  assign w_legal = w_any & ~(mem_read_EX_MEM_o & mem_write_EX_MEM_o)
                 & access_aligned(funct3_EX_MEM_o, alu_res_EX_MEM_o[1:0]);
  assign w_idle  = (r_state == ST_IDLE);
  assign w_start = w_idle & w_legal;

  always_comb begin
    w_st_wdata = write_data_EX_MEM_o;
    case (funct3_EX_MEM_o[1:0])
      2'b00:   w_st_wdata = {(DATA_WIDTH/8){write_data_EX_MEM_o[7:0]}};
      2'b01:   w_st_wdata = {(DATA_WIDTH/16){write_data_EX_MEM_o[15:0]}};
      default: w_st_wdata = write_data_EX_MEM_o;
    endcase
  end

  dmem_access_ctrl_load_extend #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_load_extend (
    .i_rdata   (dmem_rdata),
    .i_funct3  (r_funct3),
    .i_addr_lo (r_addr_lo),
    .o_data    (w_load_data)
  );

  always_comb begin
    w_stall = 1'b0;
    case (r_state)
      ST_IDLE:              w_stall = w_start;
      ST_REQ, ST_WAIT_RSP:  w_stall = 1'b1;
      default:              w_stall = 1'b0;
    endcase
  end

  // The IDLE-cycle flags depend on live inputs, so they are masked while in reset.
  assign mem_stall_MEM  = rst_n & w_stall;
  assign misaligned_MEM = rst_n & w_idle & w_any & ~w_legal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_req_valid <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= 4'b0000;
      r_funct3    <= 3'b000;
      r_addr_lo   <= 2'b00;
      r_read_data <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state     <= ST_REQ;
            r_req_valid <= 1'b1;
            r_we        <= mem_write_EX_MEM_o;
            r_addr      <= {alu_res_EX_MEM_o[DATA_ADDR_WIDTH-1:2], 2'b00};
            r_wdata     <= mem_write_EX_MEM_o ? w_st_wdata : '0;
            r_wstrb     <= mem_write_EX_MEM_o ?
                           store_strb(funct3_EX_MEM_o, alu_res_EX_MEM_o[1:0]) : 4'b0000;
            r_funct3    <= funct3_EX_MEM_o;
            r_addr_lo   <= alu_res_EX_MEM_o[1:0];
          end
        end
        ST_REQ: begin
          // Bus outputs return to zero once the request is accepted.
          if (dmem_req_ready) begin
            r_state     <= r_we ? ST_DONE : ST_WAIT_RSP;
            r_req_valid <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= 4'b0000;
          end
        end
        ST_WAIT_RSP: begin
          if (dmem_rsp_valid) begin
            r_read_data <= w_load_data;
            r_state     <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign dmem_req_valid = r_req_valid;
  assign dmem_we        = r_we;
  assign dmem_addr      = r_addr;
  assign dmem_wdata     = r_wdata;
  assign dmem_wstrb     = r_wstrb;
  assign read_data_MEM  = r_read_data;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed scenarios plus randomized
// accesses compared against an arithmetic reference model of the access rules.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        mem_read_EX_MEM_o = 1'b0;
  logic        mem_write_EX_MEM_o = 1'b0;
  logic [31:0] alu_res_EX_MEM_o = '0;
  logic [31:0] write_data_EX_MEM_o = '0;
  logic [2:0]  funct3_EX_MEM_o = '0;
  logic        dmem_req_valid, dmem_we;
  logic        dmem_req_ready = 1'b0;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_rsp_valid = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic [31:0] read_data_MEM;
  logic        mem_stall_MEM, misaligned_MEM;

  dmem_access_ctrl #(.DATA_WIDTH(32), .DATA_ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read_EX_MEM_o(mem_read_EX_MEM_o), .mem_write_EX_MEM_o(mem_write_EX_MEM_o),
    .alu_res_EX_MEM_o(alu_res_EX_MEM_o), .write_data_EX_MEM_o(write_data_EX_MEM_o),
    .funct3_EX_MEM_o(funct3_EX_MEM_o),
    .dmem_req_valid(dmem_req_valid), .dmem_we(dmem_we), .dmem_req_ready(dmem_req_ready),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata),
    .read_data_MEM(read_data_MEM), .mem_stall_MEM(mem_stall_MEM),
    .misaligned_MEM(misaligned_MEM)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  logic [31:0] last_rd = '0;

  // Observations gathered by run_txn for the calling test to judge.
  int          o_stall, o_mis, o_valid, o_hs;
  logic [31:0] o_addr, o_wdata, o_rd;
  logic [3:0]  o_wstrb;
  logic        o_we, o_stable, o_done;

  // ---------------- reference model ----------------
  function automatic int exp_size(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic logic [3:0] exp_wstrb(input logic [2:0] f3, input logic [31:0] addr);
    int s = exp_size(f3);
    if (s == 1) return 4'(1 << (addr % 4));
    if (s == 2) return 4'(3 << (addr % 4));
    return 4'd15;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
    int s = exp_size(f3);
    if (s == 1) return (d & 32'd255) * 32'h01010101;
    if (s == 2) return (d & 32'd65535) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] rdata);
    logic [31:0] sh = rdata >> (8 * (addr % 4));
    logic [31:0] v;
    case (f3)
      3'd0: begin v = sh & 32'd255;   if (v >= 32'd128)   v = v - 32'd256;   end
      3'd4:       v = sh & 32'd255;
      3'd1: begin v = sh & 32'd65535; if (v >= 32'd32768) v = v - 32'd65536; end
      3'd5:       v = sh & 32'd65535;
      default:    v = rdata;
    endcase
    return v;
  endfunction

  // ---------------- stimulus driver (no judging) ----------------
  task automatic run_txn(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [31:0] rdata, input int rdy_dly, input int rsp_dly,
                         input bit noise);
    bit hs_seen = 1'b0;
    int widx = 0;
    o_stall = 0; o_mis = 0; o_valid = 0; o_hs = 0; o_stable = 1'b1; o_done = 1'b0;
    o_addr = '0; o_wdata = '0; o_wstrb = '0; o_we = 1'b0; o_rd = '0;
    mem_read_EX_MEM_o = rd; mem_write_EX_MEM_o = wr; funct3_EX_MEM_o = f3;
    alu_res_EX_MEM_o = addr; write_data_EX_MEM_o = data; dmem_rdata = rdata;
    dmem_req_ready = (rdy_dly == 0); dmem_rsp_valid = noise;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      if (misaligned_MEM) o_mis++;
      if (mem_stall_MEM) o_stall++;
      if (dmem_req_valid) begin
        if (o_valid == 0) begin
          o_addr = dmem_addr; o_wdata = dmem_wdata; o_wstrb = dmem_wstrb; o_we = dmem_we;
        end else if ({dmem_addr, dmem_wdata, dmem_wstrb, dmem_we} !== {o_addr, o_wdata, o_wstrb, o_we}) begin
          o_stable = 1'b0;
        end
        o_valid++;
        if (dmem_req_ready) begin o_hs++; hs_seen = 1'b1; end
      end
      if (!mem_stall_MEM) begin
        o_done = (cyc > 0);
        o_rd = read_data_MEM;
        break;
      end
      @(posedge clk); #1;
      if (hs_seen) widx++;
      dmem_req_ready = (o_valid >= rdy_dly) || (hs_seen && noise);
      dmem_rsp_valid = hs_seen ? ((rd && !wr && widx == rsp_dly) || (wr && noise)) : noise;
    end
    @(posedge clk); #1;
    mem_read_EX_MEM_o = 1'b0; mem_write_EX_MEM_o = 1'b0;
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
    $display("txn rd=%0d wr=%0d f3=%0d addr=%h stall=%0d valid=%0d mis=%0d rd_data=%h",
             rd, wr, f3, addr, o_stall, o_valid, o_mis, o_rd);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    mem_read_EX_MEM_o = 1'b1; funct3_EX_MEM_o = 3'd2; alu_res_EX_MEM_o = 32'h40;
    #3 rst_n = 1'b0;
    #1;
    n_checks++; if (dmem_req_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", dmem_req_valid); else n_pass++;
    n_checks++; if (dmem_we !== 1'b0) $display("FAIL rst_we: got %b want 0", dmem_we); else n_pass++;
    n_checks++; if (dmem_addr !== 32'h0) $display("FAIL rst_addr: got %h want 0", dmem_addr); else n_pass++;
    n_checks++; if ({dmem_wdata, dmem_wstrb} !== 36'h0) $display("FAIL rst_wdata_wstrb: got %h/%b want 0", dmem_wdata, dmem_wstrb); else n_pass++;
    n_checks++; if (read_data_MEM !== 32'h0) $display("FAIL rst_rdata: got %h want 0", read_data_MEM); else n_pass++;
    n_checks++; if (mem_stall_MEM !== 1'b0) $display("FAIL rst_stall: got %b want 0", mem_stall_MEM); else n_pass++;
    n_checks++; if (misaligned_MEM !== 1'b0) $display("FAIL rst_mis: got %b want 0", misaligned_MEM); else n_pass++;
    mem_read_EX_MEM_o = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_sw;
    run_txn(1'b0, 1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0, 0, 1, 1'b0);
    n_checks++; if (o_addr !== 32'h100) $display("FAIL sw_addr: got %h want 00000100", o_addr); else n_pass++;
    n_checks++; if (o_wstrb !== 4'b1111) $display("FAIL sw_wstrb: got %b want 1111", o_wstrb); else n_pass++;
    n_checks++; if (o_wdata !== 32'hDEADBEEF) $display("FAIL sw_wdata: got %h want deadbeef", o_wdata); else n_pass++;
    n_checks++; if (o_we !== 1'b1) $display("FAIL sw_we: got %b want 1", o_we); else n_pass++;
    n_checks++; if (o_stall !== 2) $display("FAIL sw_stall: got %0d want 2", o_stall); else n_pass++;
    n_checks++; if (o_done !== 1'b1) $display("FAIL sw_done: got %b want 1", o_done); else n_pass++;
  endtask

  task automatic test_sb;
    run_txn(1'b0, 1'b1, 3'd0, 32'h103, 32'h000000A5, 32'h0, 0, 1, 1'b0);
    n_checks++; if (o_wdata !== 32'hA5A5A5A5) $display("FAIL sb_wdata: got %h want a5a5a5a5", o_wdata); else n_pass++;
    n_checks++; if (o_wstrb !== 4'b1000) $display("FAIL sb_wstrb: got %b want 1000", o_wstrb); else n_pass++;
    n_checks++; if (o_addr !== 32'h100) $display("FAIL sb_addr: got %h want 00000100", o_addr); else n_pass++;
  endtask

  task automatic test_lb_lbu;
    run_txn(1'b1, 1'b0, 3'd0, 32'h102, 32'h0, 32'h12805634, 0, 3, 1'b0);
    n_checks++; if (o_rd !== 32'hFFFFFF80) $display("FAIL lb_data: got %h want ffffff80", o_rd); else n_pass++;
    n_checks++; if (o_stall !== 5) $display("FAIL lb_stall: got %0d want 5", o_stall); else n_pass++;
    n_checks++; if (o_wstrb !== 4'b0000) $display("FAIL lb_wstrb: got %b want 0000", o_wstrb); else n_pass++;
    run_txn(1'b1, 1'b0, 3'd4, 32'h102, 32'h0, 32'h12805634, 0, 3, 1'b0);
    n_checks++; if (o_rd !== 32'h00000080) $display("FAIL lbu_data: got %h want 00000080", o_rd); else n_pass++;
    n_checks++; if (o_stall !== 5) $display("FAIL lbu_stall: got %0d want 5", o_stall); else n_pass++;
    last_rd = 32'h00000080;
  endtask

  task automatic test_misaligned;
    run_txn(1'b1, 1'b0, 3'd1, 32'h101, 32'h0, 32'h55555555, 0, 1, 1'b0);
    n_checks++; if (o_mis !== 1) $display("FAIL lh_mis: got %0d want 1", o_mis); else n_pass++;
    n_checks++; if (o_valid !== 0) $display("FAIL lh_valid: got %0d want 0", o_valid); else n_pass++;
    n_checks++; if (o_stall !== 0) $display("FAIL lh_stall: got %0d want 0", o_stall); else n_pass++;
    n_checks++; if (o_rd !== last_rd) $display("FAIL lh_rdata: got %h want %h", o_rd, last_rd); else n_pass++;
  endtask

  task automatic test_lw_backpressure;
    run_txn(1'b1, 1'b0, 3'd2, 32'h204, 32'h0, 32'hCAFEF00D, 4, 1, 1'b1);
    n_checks++; if (o_valid !== 5) $display("FAIL lw_bp_valid_cycles: got %0d want 5", o_valid); else n_pass++;
    n_checks++; if (o_stable !== 1'b1) $display("FAIL lw_bp_stable: got %b want 1", o_stable); else n_pass++;
    n_checks++; if (o_hs !== 1) $display("FAIL lw_bp_handshakes: got %0d want 1", o_hs); else n_pass++;
    n_checks++; if (o_addr !== 32'h204) $display("FAIL lw_bp_addr: got %h want 00000204", o_addr); else n_pass++;
    n_checks++; if (o_rd !== 32'hCAFEF00D) $display("FAIL lw_bp_data: got %h want cafef00d", o_rd); else n_pass++;
    n_checks++; if (o_stall !== 7) $display("FAIL lw_bp_stall: got %0d want 7", o_stall); else n_pass++;
    last_rd = 32'hCAFEF00D;
  endtask

  task automatic test_idle;
    dmem_req_ready = 1'b1; dmem_rsp_valid = 1'b1; dmem_rdata = 32'h13579BDF;
    repeat (2) @(negedge clk);
    n_checks++; if ({dmem_req_valid, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb} !== 70'h0)
      $display("FAIL idle_bus: got v=%b we=%b a=%h d=%h s=%b want all 0", dmem_req_valid, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb); else n_pass++;
    n_checks++; if (mem_stall_MEM !== 1'b0) $display("FAIL idle_stall: got %b want 0", mem_stall_MEM); else n_pass++;
    n_checks++; if (read_data_MEM !== last_rd) $display("FAIL idle_hold: got %h want %h", read_data_MEM, last_rd); else n_pass++;
    @(posedge clk); #1;
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
  endtask

  task automatic test_random;
    for (int t = 0; t < 60; t++) begin
      int kind, rdy, rsp, s;
      logic rd, wr, legal;
      logic [2:0] f3;
      logic [31:0] addr, data, rdata, exp_rd;
      bit noise;
      kind = $urandom_range(0, 9);
      rd = (kind < 5); wr = (kind >= 5 && kind < 9);
      if (kind == 9) begin rd = 1'($urandom_range(0, 1)); wr = rd; end
      f3 = 3'($urandom_range(0, 7));
      if (wr && !rd && (f3 == 3'd4 || f3 == 3'd5)) f3 = f3 - 3'd4;
      addr = $urandom; data = $urandom; rdata = $urandom;
      if ($urandom_range(0, 1) == 1) addr = addr & 32'hFFFFFFFC;
      rdy = $urandom_range(0, 3); rsp = $urandom_range(1, 3); noise = 1'($urandom_range(0, 1));
      s = exp_size(f3);
      legal = (rd != wr) && (s != 0) && ((addr % s) == 0);
      exp_rd = (legal && rd) ? exp_load(f3, addr, rdata) : last_rd;
      run_txn(rd, wr, f3, addr, data, rdata, rdy, rsp, noise);
      n_checks++; if (o_stall !== (!legal ? 0 : (wr ? rdy + 2 : rdy + 2 + rsp)))
        $display("FAIL rnd%0d_stall: got %0d want %0d", t, o_stall, !legal ? 0 : (wr ? rdy + 2 : rdy + 2 + rsp)); else n_pass++;
      n_checks++; if (o_mis !== ((rd || wr) && !legal ? 1 : 0))
        $display("FAIL rnd%0d_mis: got %0d want %0d", t, o_mis, (rd || wr) && !legal ? 1 : 0); else n_pass++;
      n_checks++; if (o_hs !== (legal ? 1 : 0)) $display("FAIL rnd%0d_hs: got %0d want %0d", t, o_hs, legal ? 1 : 0); else n_pass++;
      n_checks++; if (o_done !== legal) $display("FAIL rnd%0d_done: got %b want %b", t, o_done, legal); else n_pass++;
      n_checks++; if (o_rd !== exp_rd) $display("FAIL rnd%0d_rdata: got %h want %h", t, o_rd, exp_rd); else n_pass++;
      if (legal) begin
        n_checks++; if (o_addr !== (addr & 32'hFFFFFFFC)) $display("FAIL rnd%0d_addr: got %h want %h", t, o_addr, addr & 32'hFFFFFFFC); else n_pass++;
        n_checks++; if (o_wstrb !== (wr ? exp_wstrb(f3, addr) : 4'b0000)) $display("FAIL rnd%0d_wstrb: got %b want %b", t, o_wstrb, wr ? exp_wstrb(f3, addr) : 4'b0000); else n_pass++;
        n_checks++; if (o_we !== wr) $display("FAIL rnd%0d_we: got %b want %b", t, o_we, wr); else n_pass++;
        n_checks++; if (o_valid !== rdy + 1 || o_stable !== 1'b1) $display("FAIL rnd%0d_hold: got %0d cycles stable=%b want %0d stable=1", t, o_valid, o_stable, rdy + 1); else n_pass++;
        if (wr) begin
          n_checks++; if (o_wdata !== exp_wdata(f3, data)) $display("FAIL rnd%0d_wdata: got %h want %h", t, o_wdata, exp_wdata(f3, data)); else n_pass++;
        end
      end
      last_rd = exp_rd;
    end
  endtask

  task automatic test_reset_mid;
    mem_read_EX_MEM_o = 1'b1; funct3_EX_MEM_o = 3'd2; alu_res_EX_MEM_o = 32'h300;
    dmem_req_ready = 1'b1; dmem_rsp_valid = 1'b0; dmem_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++; if ({mem_stall_MEM, dmem_req_valid} !== 2'b10) $display("FAIL mid_wait_state: got stall=%b valid=%b want 1/0", mem_stall_MEM, dmem_req_valid); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (mem_stall_MEM !== 1'b0) $display("FAIL mid_rst_stall: got %b want 0", mem_stall_MEM); else n_pass++;
    n_checks++; if (read_data_MEM !== 32'h0) $display("FAIL mid_rst_rdata: got %h want 0", read_data_MEM); else n_pass++;
    last_rd = 32'h0;
    mem_read_EX_MEM_o = 1'b0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    dmem_rsp_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (read_data_MEM !== 32'h0) $display("FAIL mid_stray_rsp_rdata: got %h want 0", read_data_MEM); else n_pass++;
    n_checks++; if ({mem_stall_MEM, dmem_req_valid} !== 2'b00) $display("FAIL mid_stray_rsp_idle: got stall=%b valid=%b want 0/0", mem_stall_MEM, dmem_req_valid); else n_pass++;
    dmem_rsp_valid = 1'b0; dmem_req_ready = 1'b0;
    @(posedge clk); #1;
    run_txn(1'b1, 1'b0, 3'd5, 32'h302, 32'h0, 32'h8001ABCD, 1, 2, 1'b0);
    n_checks++; if (o_rd !== 32'h00008001) $display("FAIL mid_recover_lhu: got %h want 00008001", o_rd); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sw();
    test_sb();
    test_lb_lbu();
    test_misaligned();
    test_lw_backpressure();
    test_idle();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
